// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types, defaults and saturating adder for the systolic array
//
// Purpose: common definitions imported by every PE flavour.
//   pe_state_t : PE tile FSM encoding (IDLE, ACCUM, DONE, DRAIN)
//   sat_add    : accumulate with overflow detect and optional clamp
//   DEF_*      : default array widths
//   ACC_MAX    : working width of sat_add; PE accumulators must be narrower
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } pe_state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 40;
  localparam int ACC_MAX        = 64;

  typedef struct packed {
    logic               ovf;
    logic [ACC_MAX-1:0] sum;
  } sat_add_t;

  // acc and p arrive already sign/zero-extended to ACC_MAX bits, so the
  // ACC_MAX-bit sum is exact; overflow is then a range test at 'width' bits.
  // The returned sum is masked to 'width' bits.
  function automatic sat_add_t sat_add(input logic [ACC_MAX-1:0] acc,
                                       input logic [ACC_MAX-1:0] p,
                                       input int                 width,
                                       input logic               is_signed,
                                       input logic               saturate);
    logic [ACC_MAX-1:0] one;
    logic [ACC_MAX-1:0] mask;
    logic [ACC_MAX-1:0] hi;
    logic [ACC_MAX-1:0] lo;
    logic [ACC_MAX-1:0] sum;
    sat_add_t           r;
    one   = {{(ACC_MAX-1){1'b0}}, 1'b1};
    mask  = (one << width) - one;
    sum   = acc + p;
    r.sum = sum;
    r.ovf = 1'b0;
    if (is_signed) begin
      hi    = (one << (width - 1)) - one;
      lo    = ~hi;                          // -2^(width-1), sign-extended
      r.ovf = ($signed(sum) > $signed(hi)) || ($signed(sum) < $signed(lo));
      if (r.ovf && saturate) r.sum = sum[ACC_MAX-1] ? lo : hi;
    end else begin
      hi    = mask;
      lo    = '0;
      r.ovf = |(sum & ~mask);
      if (r.ovf && saturate) r.sum = hi;
    end
    r.sum = r.sum & mask;
    return r;
  endfunction

endpackage

// File: rtl/pe_mul_stage.sv
// rtl/pe_mul_stage.sv - registered multiplier stage with valid/last pipeline
//
// Purpose: stage 1 of a PE; registers p = a*b at full product width.
// Ports:
//   clk, rst          : clock, async active-high reset
//   a, b              : operands (DATA_WIDTH)
//   in_valid, in_last : pair qualifier and end-of-tile tag
//   p                 : registered product (2*DATA_WIDTH)
//   p_valid, p_last   : registered qualifiers aligned with p
module pe_mul_stage
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit SIGNED     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic [2*DATA_WIDTH-1:0] p,
  output logic                    p_valid,
  output logic                    p_last
);

  localparam int PW = 2 * DATA_WIDTH;

  logic          a_sx;
  logic          b_sx;
  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] prod;

  // Extending both operands to the product width makes a plain unsigned
  // multiply give the correct low PW bits for either signedness.
  assign a_sx  = SIGNED & a[DATA_WIDTH-1];
  assign b_sx  = SIGNED & b[DATA_WIDTH-1];
  assign a_ext = {{DATA_WIDTH{a_sx}}, a};
  assign b_ext = {{DATA_WIDTH{b_sx}}, b};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p       <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else begin
      p_valid <= in_valid;
      p_last  <= in_valid & in_last;
      if (in_valid) p <= prod;
    end
  end

endmodule

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - output-stationary systolic processing element
//
// Purpose: multiply-accumulate streaming A/B operands over one tile, hold the
// result, then shift it south on the C chain during the drain window.
// Ports:
//   clk, rst                   : clock, async active-high reset
//   a_in, b_in                 : operands from west / north
//   in_valid, in_last          : pair valid, last pair of tile
//   a_out, b_out               : registered operand forward east / south
//   out_valid, out_last        : registered forward of in_valid / in_valid&in_last
//   drain                      : array-wide drain window
//   c_in, c_valid_in           : result chain from upstream PE
//   c_out, c_valid_out         : result chain to downstream PE
//   result_ready               : tile complete, result held
//   overflow                   : sticky accumulate overflow for this tile
//   protocol_err               : sticky, operands arrived while not accepting
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter bit SIGNED     = 1'b1,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  drain,
  input  logic [ACC_WIDTH-1:0]  c_in,
  input  logic                  c_valid_in,
  output logic [ACC_WIDTH-1:0]  c_out,
  output logic                  c_valid_out,
  output logic                  result_ready,
  output logic                  overflow,
  output logic                  protocol_err
);

  localparam int PW = 2 * DATA_WIDTH;

  if (ACC_WIDTH < PW) begin : g_bad_acc
    $error("systolic_pe: ACC_WIDTH must be at least 2*DATA_WIDTH");
  end
  if (ACC_WIDTH >= ACC_MAX) begin : g_wide_acc
    $error("systolic_pe: ACC_WIDTH must be below ACC_MAX");
  end

  pe_state_t              state;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   drain_first;
  logic                   accepting;
  logic                   mul_valid;
  logic [PW-1:0]          p;
  logic                   p_valid;
  logic                   p_last;
  logic [ACC_MAX-1:0]     acc_ext;
  logic [ACC_MAX-1:0]     p_ext;
  sat_add_t               add_r;
  logic [ACC_WIDTH-1:0]   sum_next;
  logic                   unused_sum_hi;

  // Once the last pair of a tile sits in stage 1 the tile is closed, even
  // though the FSM only reaches DONE on the next edge.
  assign accepting = ((state == IDLE) || (state == ACCUM)) && !(p_valid && p_last);
  assign mul_valid = in_valid & accepting;

  pe_mul_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIGNED     (SIGNED)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .a        (a_in),
    .b        (b_in),
    .in_valid (mul_valid),
    .in_last  (in_last),
    .p        (p),
    .p_valid  (p_valid),
    .p_last   (p_last)
  );

  assign acc_ext       = {{(ACC_MAX-ACC_WIDTH){SIGNED & acc[ACC_WIDTH-1]}}, acc};
  assign p_ext         = {{(ACC_MAX-PW){SIGNED & p[PW-1]}}, p};
  assign add_r         = sat_add(acc_ext, p_ext, ACC_WIDTH, SIGNED, SATURATE);
  assign sum_next      = add_r.sum[ACC_WIDTH-1:0];
  assign unused_sum_hi = ^add_r.sum[ACC_MAX-1:ACC_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      drain_first  <= 1'b0;
      a_out        <= '0;
      b_out        <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      c_out        <= '0;
      c_valid_out  <= 1'b0;
      result_ready <= 1'b0;
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      a_out       <= a_in;
      b_out       <= b_in;
      out_valid   <= in_valid;
      out_last    <= in_valid & in_last;
      // Chain passes through unless this PE is injecting its own result.
      c_out       <= c_in;
      c_valid_out <= c_valid_in;

      if (in_valid && !accepting) protocol_err <= 1'b1;

      case (state)
        IDLE, ACCUM: begin
          if (p_valid) begin
            acc <= sum_next;
            if (add_r.ovf) overflow <= 1'b1;
            if (p_last) begin
              state        <= DONE;
              result_ready <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (drain) begin
            state        <= DRAIN;
            drain_first  <= 1'b1;
            result_ready <= 1'b0;
          end
        end
        DRAIN: begin
          drain_first <= 1'b0;
          if (drain_first) begin
            c_out       <= acc;
            c_valid_out <= 1'b1;
          end
          if (!drain) begin
            state        <= IDLE;
            acc          <= '0;
            overflow     <= 1'b0;
            protocol_err <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_pe.sv
// tb/tb_systolic_pe.sv - scoreboard bench for systolic_pe
//
// Instances: 0 signed/sat 40b, 1 unsigned/sat 32b, 2 unsigned/wrap 32b,
// 3 -> 4 signed two-PE drain chain.
module tb_systolic_pe;

  localparam int N = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       rst;
  logic [N-1:0][15:0] a_i, b_i, a_o, b_o;
  logic [N-1:0]       iv, il, dr;
  logic [N-1:0]       ov, ol, rr, ovf, perr, cvo;
  logic [N-1:0][39:0] c_all;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int AW = (g == 1 || g == 2) ? 32 : 40;
    logic [AW-1:0] c_in_w;
    logic [AW-1:0] c_out_w;
    logic          c_vin;
    assign c_in_w   = (g == 4) ? c_all[3][AW-1:0] : '0;
    assign c_vin    = (g == 4) ? cvo[3] : 1'b0;
    assign c_all[g] = 40'(c_out_w);
    systolic_pe #(
      .DATA_WIDTH (16),
      .ACC_WIDTH  (AW),
      .SIGNED     (g != 1 && g != 2),
      .SATURATE   (g != 2)
    ) u_pe (
      .clk          (clk),
      .rst          (rst[g]),
      .a_in         (a_i[g]),
      .b_in         (b_i[g]),
      .in_valid     (iv[g]),
      .in_last      (il[g]),
      .a_out        (a_o[g]),
      .b_out        (b_o[g]),
      .out_valid    (ov[g]),
      .out_last     (ol[g]),
      .drain        (dr[g]),
      .c_in         (c_in_w),
      .c_valid_in   (c_vin),
      .c_out        (c_out_w),
      .c_valid_out  (cvo[g]),
      .result_ready (rr[g]),
      .overflow     (ovf[g]),
      .protocol_err (perr[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [39:0] exp_q [N][$];
  longint      m_acc [N];
  bit          m_ovf [N];
  int          m_w   [N];
  bit          m_sgn [N];
  bit          m_sat [N];
  int          pop_cyc [N];
  int          pops [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference accumulate: exact sum, then clamp or wrap at the PE width.
  task automatic model_pair(input int d, input logic [15:0] av, input logic [15:0] bv,
                            input logic last);
    longint one, pr, hi, lo, full;
    one  = 1;
    full = (one << m_w[d]);
    if (m_sgn[d]) pr = longint'($signed(av)) * longint'($signed(bv));
    else          pr = longint'(av) * longint'(bv);
    hi = m_sgn[d] ? (one << (m_w[d] - 1)) - 1 : full - 1;
    lo = m_sgn[d] ? -(one << (m_w[d] - 1)) : 0;
    m_acc[d] += pr;
    if (m_acc[d] > hi || m_acc[d] < lo) begin
      m_ovf[d] = 1'b1;
      if (m_sat[d]) m_acc[d] = (m_acc[d] > hi) ? hi : lo;
      else begin
        m_acc[d] = m_acc[d] & (full - 1);
        if (m_sgn[d] && m_acc[d] > hi) m_acc[d] -= full;
      end
    end
    if (last) begin
      exp_q[d].push_back(40'(m_acc[d] & (full - 1)));
      m_acc[d] = 0;
    end
  endtask

  task automatic drive(input logic [N-1:0] m, input logic [15:0] av, input logic [15:0] bv,
                       input logic last, input bit counted);
    for (int d = 0; d < N; d++) begin
      if (m[d]) begin
        a_i[d] = av; b_i[d] = bv; iv[d] = 1'b1; il[d] = last;
        if (counted) model_pair(d, av, bv, last);
      end
    end
    @(posedge clk); #1;
    for (int d = 0; d < N; d++) begin
      if (m[d]) begin iv[d] = 1'b0; il[d] = 1'b0; end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ready(input int d);
    int n;
    n = 0;
    while (!rr[d] && n < 50) begin @(posedge clk); #1; n++; end
    check($sformatf("ready_pe%0d", d), rr[d], 1'b1);
  endtask

  task automatic run_drain(input logic [N-1:0] m);
    dr = m;
    tick(4);
    dr = '0;
    tick(2);
  endtask

  // Scoreboard: every c_valid_out must match the next queued result.
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int d = 0; d < N; d++) begin
      if (cvo[d]) begin
        check($sformatf("c_expected_pe%0d", d), exp_q[d].size() > 0, 1'b1);
        if (exp_q[d].size() > 0) begin
          check($sformatf("c_out_pe%0d", d), c_all[d], exp_q[d].pop_front());
          if (d == 4 && pops[d] > 0)
            check("chain_consecutive", cyc - pop_cyc[d], 1);
          pops[d]++;
          pop_cyc[d] = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = '1; a_i = '0; b_i = '0; iv = '0; il = '0; dr = '0;
    for (int d = 0; d < N; d++) begin
      m_acc[d] = 0; m_ovf[d] = 0; pops[d] = 0; pop_cyc[d] = 0;
      m_w[d]   = (d == 1 || d == 2) ? 32 : 40;
      m_sgn[d] = (d != 1 && d != 2);
      m_sat[d] = (d != 2);
    end
    tick(2);
    check("rst_flags_pe0", {a_o[0], b_o[0], ov[0], ol[0], rr[0], ovf[0], perr[0], cvo[0]}, '0);
    check("rst_c_pe4", c_all[4], '0);
    rst = '0;
    tick(1);

    // Signed dot product, latency to result_ready, then a stray pair in DONE.
    drive(5'b00001, 16'd3, 16'd4, 1'b0, 1);
    drive(5'b00001, 16'hFFFB, 16'd6, 1'b0, 1);
    drive(5'b00001, 16'd7, 16'hFFF8, 1'b1, 1);
    check("t1_rr_early", rr[0], 1'b0);
    tick(1);
    check("t1_rr_lat", rr[0], 1'b1);
    check("t1_ovf", ovf[0], 1'b0);
    drive(5'b00001, 16'd9, 16'd9, 1'b0, 0);
    check("perr_a_fwd", a_o[0], 16'd9);
    check("perr_b_fwd", b_o[0], 16'd9);
    check("perr_v_fwd", ov[0], 1'b1);
    tick(2);
    check("perr_set", perr[0], 1'b1);
    check("perr_rr_held", rr[0], 1'b1);
    run_drain(5'b00001);
    check("perr_clr", perr[0], 1'b0);
    check("t1_rr_clr", rr[0], 1'b0);

    // Unsigned overflow: saturating and wrapping variants in parallel.
    for (int i = 0; i < 3; i++) drive(5'b00110, 16'hFFFF, 16'hFFFF, i == 2, 1);
    wait_ready(1);
    wait_ready(2);
    check("ovf_sat", ovf[1], m_ovf[1]);
    check("ovf_wrap", ovf[2], m_ovf[2]);
    run_drain(5'b00110);
    check("ovf_clr_sat", ovf[1], 1'b0);
    check("ovf_clr_wrap", ovf[2], 1'b0);

    // Two-PE chain: PE1 shows its own 20 then upstream 10.
    drive(5'b01000, 16'd2, 16'd5, 1'b1, 1);
    drive(5'b10000, 16'd4, 16'd5, 1'b1, 1);
    exp_q[4].push_back(40'd10);
    wait_ready(3);
    wait_ready(4);
    run_drain(5'b11000);
    check("chain_pops", pops[4], 2);

    // Reset mid-tile, then a fresh single-pair tile.
    drive(5'b00001, 16'd5, 16'd5, 1'b0, 1);
    drive(5'b00001, 16'd6, 16'd6, 1'b0, 1);
    rst[0] = 1'b1;
    m_acc[0] = 0;
    #1;
    check("midrst_flags", {a_o[0], b_o[0], ov[0], ol[0], rr[0], ovf[0], perr[0], cvo[0]}, '0);
    check("midrst_c", c_all[0], '0);
    tick(1);
    rst[0] = 1'b0;
    tick(1);
    drive(5'b00001, 16'd2, 16'd2, 1'b1, 1);
    wait_ready(0);
    run_drain(5'b00001);

    // Gapped input: result_ready exactly two cycles after the last pair.
    drive(5'b00001, 16'd1, 16'd1, 1'b0, 1);
    tick(2);
    drive(5'b00001, 16'd2, 16'd2, 1'b1, 1);
    check("gap_rr_early", rr[0], 1'b0);
    tick(1);
    check("gap_rr_lat", rr[0], 1'b1);
    run_drain(5'b00001);

    tick(3);
    for (int d = 0; d < N; d++) check($sformatf("q_empty_pe%0d", d), exp_q[d].size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/systolic_pe.md
# systolic_pe

Parametrised output-stationary processing element for the systolic matrix-multiply array. Each PE multiplies streaming A (west→east) and B (north→south) operands and accumulates them over one tile. Tiles are delimited by a `last` tag. Finished results are drained south through a dedicated C shift chain while operands keep flowing to neighbours. Supersedes the single-width, unhandshaked MAC.

## Interface
- `DATA_WIDTH`, 16, operand width
- `ACC_WIDTH`, 40, accumulator width; must be ≥ 2·DATA_WIDTH (elaboration error otherwise)
- `SIGNED`, 1, 1 = two's-complement operands, 0 = unsigned
- `SATURATE`, 1, 1 = clamp accumulator on overflow, 0 = wrap modulo 2^ACC_WIDTH

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `a_in`, `b_in` in DATA_WIDTH: operands
- `in_valid` in 1: operand pair valid
- `in_last` in 1: qualifies `in_valid`; this pair is the last of the tile
- `a_out`, `b_out` out DATA_WIDTH: registered operand forward
- `out_valid`, `out_last` out 1: registered forward of `in_valid` / `in_last`
- `drain` in 1: drain window active (array-wide, held high)
- `c_in` in ACC_WIDTH, `c_valid_in` in 1: result chain from the upstream PE
- `c_out` out ACC_WIDTH, `c_valid_out` out 1: result chain to the downstream PE
- `result_ready` out 1: tile complete, result held
- `overflow` out 1: sticky; set if any accumulate in the tile overflowed
- `protocol_err` out 1: sticky; set if operands arrive while the PE is not accepting

## Operation
- Forwarding is unconditional in every state. Each cycle: `a_out`←`a_in`, `b_out`←`b_in`, `out_valid`←`in_valid`, `out_last`←`in_valid & in_last`.
- Pipeline stage 1 registers product `p = a_in*b_in` (2·DATA_WIDTH bits, signedness per `SIGNED`), plus `p_valid`/`p_last`.
- Stage 2 forms `acc + sext/zext(p)` at ACC_WIDTH+1 bits.
  - Overflow: bits [ACC_WIDTH] and [ACC_WIDTH-1] differ (signed), or the carry is set (unsigned).
  - SATURATE=1 clamps to max/min; SATURATE=0 truncates. Either way, overflow sets `overflow`.
- FSM states:
  - IDLE: acc=0; a valid pair → ACCUM.
  - ACCUM: accumulate each `p_valid`; when `p_valid & p_last` is accumulated → DONE.
  - DONE: `result_ready`=1, acc frozen; `drain`=1 → DRAIN.
  - DRAIN: first cycle loads acc onto `c_out` with `c_valid_out`=1. Subsequent cycles set `c_out`←`c_in` and `c_valid_out`←`c_valid_in`. `drain`=0 → IDLE, clearing acc, `overflow` and `protocol_err`.
- A single-pair tile (first pair carries `in_last`) is legal.
- A pair arriving in DONE or DRAIN is forwarded but not accumulated, and sets `protocol_err`.
- `drain` asserted in IDLE or ACCUM is ignored for this PE. The chain still passes through: `c_out`←`c_in`.

## Timing
- Reset (async, immediate): all outputs 0, acc 0, pipeline valids 0, state IDLE.
- Operand forward latency is 1 cycle.
- Pair at edge N affects acc at edge N+2. With the last pair at edge N, `result_ready`=1 from edge N+2.
- Back-to-back pairs accumulate at full rate, one per cycle; gaps in `in_valid` are allowed.
- Own result appears on `c_out` 1 cycle after the first `drain`-high edge seen in DONE.
- Reset mid-tile or mid-drain discards all state; no partial result is emitted.
- New tile operands are accepted from the cycle after the DRAIN→IDLE edge.

## Structure
- Shared package `systolic_pkg`:
  - `pe_state_t` enum (IDLE, ACCUM, DONE, DRAIN)
  - function `sat_add(acc, p, signed, saturate)` returning the sum and an overflow flag
  - default width localparams for the array
- One sub-module, `pe_mul_stage`: stage-1 registered multiplier with valid/last pipeline, reused by future PE variants.

## Test plan
- DATA_WIDTH=16, SIGNED=1: pairs (3,4),(−5,6),(7,−8 last) → after drain `c_out`=−74 (0x…FFB6), `overflow`=0.
- SIGNED=0, ACC_WIDTH=32, SATURATE=1: 3 pairs (0xFFFF,0xFFFF) → `c_out`=0xFFFFFFFF, `overflow`=1. Same with SATURATE=0 → 0xFFFA0003.
- Two-PE chain drain: PE0=10, PE1=20 → PE1 `c_out` shows 20 then 10 on consecutive cycles with `c_valid_out`=1.
- Pair sent while DONE → forwarded on `a_out`/`b_out` next cycle, acc unchanged, `protocol_err`=1; cleared after drain.
- Assert `rst` mid-tile after 2 pairs → all outputs 0 immediately. A fresh tile (2,2 last) yields 4.
- Gapped input `in_valid`=1,0,0,1(last) with (1,1),(2,2) → `result_ready` 2 cycles after the last pair, result 5.
